// File: rtl/axi_pkg.sv
// Shared types for the AXI read interconnect.
// Master select, response codes and read-return FSM states.
package axi_pkg;

  typedef logic master_sel_t;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } axi_resp_t;

  typedef enum logic {
    RR_EMPTY = 1'b0,
    RR_ROUTE = 1'b1
  } rr_state_t;

endpackage

// File: rtl/axi_owner_fifo.sv
// In-order owner FIFO: one master select per outstanding burst.
// Push while full is dropped even if a pop happens the same cycle.
module axi_owner_fifo
  import axi_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH),
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_push,
  input  logic             i_src,
  input  logic             i_pop,
  output logic             o_head,
  output logic             o_full,
  output logic             o_push_ok,
  output logic [CNT_W-1:0] o_count
);

  master_sel_t      r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign w_push    = i_push && !o_full;
  assign w_pop     = i_pop && (r_count != '0);
  assign o_push_ok = w_push;
  assign o_head    = r_mem[r_rd_ptr];
  assign o_count   = r_count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset; entries are only read once written.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_src;
  end

endmodule

// File: rtl/axi_read_resp_router.sv
// Read-return router: steers shared slave R beats to the owning master.
// Owner comes from the FIFO head; head pops on each burst's last beat.
module axi_read_resp_router
  import axi_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ord_push,
  input  logic              ord_src,
  output logic              ord_full,
  output logic [CNT_W-1:0]  outstanding,
  input  logic              m_rvalid,
  output logic              m_rready,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic [1:0]        m_rresp,
  input  logic              m_rlast,
  output logic              s0_rvalid,
  input  logic              s0_rready,
  output logic [DATA_W-1:0] s0_rdata,
  output logic [1:0]        s0_rresp,
  output logic              s0_rlast,
  output logic              s1_rvalid,
  input  logic              s1_rready,
  output logic [DATA_W-1:0] s1_rdata,
  output logic [1:0]        s1_rresp,
  output logic              s1_rlast,
  output logic              err_unexp
);

  rr_state_t        r_state;
  logic             r_err;
  logic             w_head;
  logic             w_route;
  logic             w_fire;
  logic             w_pop;
  logic             w_push_ok;
  logic             w_full;
  logic [CNT_W-1:0] w_count;

  axi_owner_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_push    (ord_push),
    .i_src     (ord_src),
    .i_pop     (w_pop),
    .o_head    (w_head),
    .o_full    (w_full),
    .o_push_ok (w_push_ok),
    .o_count   (w_count)
  );

  assign w_route = (r_state == RR_ROUTE);

  // Empty state sinks stray beats so the slave never stalls.
  assign m_rready  = reset_n &&
                     (w_route ? (w_head ? s1_rready : s0_rready)
                              : 1'b1);
  assign s0_rvalid = w_route && !w_head && m_rvalid;
  assign s1_rvalid = w_route &&  w_head && m_rvalid;

  assign s0_rdata = m_rdata;
  assign s1_rdata = m_rdata;
  assign s0_rresp = m_rresp;
  assign s1_rresp = m_rresp;
  assign s0_rlast = m_rlast;
  assign s1_rlast = m_rlast;

  assign w_fire = m_rvalid && m_rready;
  assign w_pop  = w_route && w_fire && m_rlast;

  assign ord_full    = w_full;
  assign outstanding = w_count;
  assign err_unexp   = r_err;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= RR_EMPTY;
      r_err   <= 1'b0;
    end else begin
      r_err <= !w_route && w_fire;
      unique case (1'b1)
        (r_state == RR_EMPTY): begin
          if (w_push_ok) r_state <= RR_ROUTE;
        end
        default: begin
          if (w_pop && !w_push_ok &&
              w_count == CNT_W'(1))
            r_state <= RR_EMPTY;
        end
      endcase
    end
  end

endmodule
